rejsam_eta_vec: RTL and testbench
=================================

// Module: rejsam_eta_vec
// PURPOSE
//  Secret-vector sampler for ML-DSA key generation: rejection-samples NUM_POLY polynomials of
//  N_COEFF small coefficients (eta=2 or eta=4) from SHAKE256 output, one SHAKE run per polynomial.
//  Scans LANES nibbles per cycle, buffers accepted values in a FIFO and streams them out under
//  valid/ready backpressure. Drives an external SHAKE256 core; feeds the s1/s2 NTT path.
// PARAMETERS
//  N_COEFF     256   coefficients per polynomial
//  RATE_BITS   1088  SHAKE256 squeeze block width; RATE_BITS % (4*LANES) must be 0
//  LANES       2     nibbles examined per PROCESS cycle (1, 2 or 4)
//  FIFO_DEPTH  8     output FIFO entries (power of 2, >= 2*LANES)
// PORTS
//  clk              in   1          clock
//  rst_n            in   1          asynchronous active-low reset
//  i_start          in   1          start pulse; ignored while o_busy=1
//  i_abort          in   1          synchronous abort of current run
//  i_eta_mode       in   1          0: eta=2 (nibble<15, out=nibble mod 5); 1: eta=4 (nibble<9, out=nibble)
//  i_num_poly       in   4          polynomials to generate; 0 treated as 1
//  i_row_base       in   16         row nonce of first polynomial
//  i_rho_prime      in   512        seed rho'
//  o_shake_start    out  1          one-cycle SHAKE start pulse
//  o_shake_seed     out  528        {row_base+poly_idx, rho_prime}, stable from start to poly end
//  i_shake_busy     in   1          SHAKE core busy (monitor only)
//  o_squeeze_req    out  1          one-cycle squeeze request pulse
//  i_squeeze_valid  in   1          squeeze data valid (level)
//  i_squeeze_data   in   RATE_BITS  squeezed block, nibble k = bits [4k+3:4k]
//  o_coeff_valid    out  1          FIFO head valid
//  i_coeff_ready    in   1          consumer accepts head when valid&ready
//  o_coeff_data     out  4          coefficient value 0..8 (caller forms eta - value)
//  o_coeff_idx      out  8          coefficient index within polynomial
//  o_poly_idx       out  4          polynomial index of head
//  o_poly_last      out  1          head is coeff N_COEFF-1 of its polynomial
//  o_busy           out  1          high from accepted start until done/abort
//  o_done           out  1          one-cycle pulse after final coefficient is popped
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, counters 0.
//  States: IDLE->START (latch mode/num_poly/row_base/rho; poly_idx=0) ->REQ (o_shake_start pulse
//   previous cycle, o_squeeze_req pulse) ->WAIT_ACK (wait i_squeeze_valid=0) ->WAIT_DATA (on
//   i_squeeze_valid=1 capture block, bit_ptr=0) ->PROCESS ->NEXT_POLY ->START or DRAIN ->DONE->IDLE.
//  PROCESS per cycle: if FIFO free slots < LANES, stall (no ptr move). Else test nibbles
//   bit_ptr..bit_ptr+4*LANES-1 in ascending order; push accepted ones in order, each incrementing
//   coeff_cnt; candidates after coeff_cnt reaches N_COEFF are discarded; bit_ptr += 4*LANES.
//  Buffer exhausted (bit_ptr == RATE_BITS) with coeff_cnt<N_COEFF -> REQ for next block.
//  coeff_cnt==N_COEFF -> NEXT_POLY: poly_idx++, coeff_cnt=0; if poly_idx==num_poly-1 go DRAIN,
//   else START (new SHAKE run, row = row_base+poly_idx, 16-bit wrap).
//  DRAIN: wait FIFO empty, then o_done=1 for one cycle, o_busy=0 the same cycle, return IDLE.
//  FIFO: push and pop in same cycle allowed; pop only when valid&ready; data never dropped.
//  eta=2 mod 5 by compare/subtract: >=10 -> -10, >=5 -> -5.
//  i_abort (any state): next cycle IDLE, FIFO flushed, o_coeff_valid=0, no o_done; abort beats start.
//  i_start during busy ignored; i_start in DONE-cycle ignored; mode inputs sampled only at START.
// TESTING
//  eta=4, LANES=2, nibbles all 3, num_poly=1, ready=1 -> 256 coeffs of 3, poly_last on #255,
//   one squeeze, single o_done pulse.
//  eta=2, nibble pattern 0xF,0xE,0x9,0x4 repeated -> outputs 4,4,4 per 4 nibbles (0xF rejected), idx 0..255.
//  Block of all 0xF then valid block -> second o_squeeze_req issued, no coeff from first block.
//  num_poly=3, row_base=0xFFFF -> three o_shake_start pulses, seeds rows 0xFFFF,0x0000,0x0001; poly_idx 0,1,2.
//  i_coeff_ready random 30% -> FIFO never overflows, stream identical to ready=1 run.
//  i_abort mid-poly 1 -> o_busy=0 next cycle, no o_done; new i_start restarts at poly_idx 0.

Source files
------------

// File: rtl/rejsam_eta_vec.sv
// ML-DSA secret-vector sampler: rejection-samples small (eta=2/4) coefficients
// from SHAKE256 squeeze blocks and streams them out through a small FIFO.
module rejsam_eta_vec #(
  parameter int unsigned N_COEFF    = 256,
  parameter int unsigned RATE_BITS  = 1088,
  parameter int unsigned LANES      = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_eta_mode,
  input  logic [3:0]           i_num_poly,
  input  logic [15:0]          i_row_base,
  input  logic [511:0]         i_rho_prime,
  output logic                 o_shake_start,
  output logic [527:0]         o_shake_seed,
  input  logic                 i_shake_busy,
  output logic                 o_squeeze_req,
  input  logic                 i_squeeze_valid,
  input  logic [RATE_BITS-1:0] i_squeeze_data,
  output logic                 o_coeff_valid,
  input  logic                 i_coeff_ready,
  output logic [3:0]           o_coeff_data,
  output logic [7:0]           o_coeff_idx,
  output logic [3:0]           o_poly_idx,
  output logic                 o_poly_last,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CCW = $clog2(N_COEFF + 1);
  localparam int unsigned BPW = $clog2(RATE_BITS + 1);
  localparam int unsigned EW  = 17;
  localparam logic [CCW-1:0] N_C     = CCW'(N_COEFF);
  localparam logic [CCW-1:0] LAST_C  = CCW'(N_COEFF - 1);
  localparam logic [BPW-1:0] RATE_L  = BPW'(RATE_BITS);
  localparam logic [BPW-1:0] STEP    = BPW'(4 * LANES);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  LANES_C = CW'(LANES);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_REQ, S_WAIT_ACK, S_WAIT_DATA,
    S_PROCESS, S_NEXT_POLY, S_DRAIN, S_DONE
  } state_t;

  state_t               state;
  logic                 eta4;
  logic [3:0]           num_last;
  logic [15:0]          row_base;
  logic [511:0]         rho;
  logic [3:0]           poly_idx;
  logic [CCW-1:0]       coeff_cnt;
  logic [BPW-1:0]       bit_ptr;
  logic [RATE_BITS-1:0] blk;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;

  logic                 do_proc, pop;
  logic [LANES-1:0]     acc;
  logic [3:0]           nib [LANES];
  logic [3:0]           val [LANES];
  logic [EW-1:0]        ent [LANES];
  logic [PW-1:0]        lane_off [LANES];
  logic [CW-1:0]        push_n;
  logic [CCW-1:0]       cnt_nxt;

  logic unused_shake_busy;
  assign unused_shake_busy = i_shake_busy;

  assign do_proc = (state == S_PROCESS) && ((DEPTH_C - count) >= LANES_C);
  assign pop     = o_coeff_valid && i_coeff_ready;

  assign o_coeff_valid = (count != '0);
  assign {o_coeff_data, o_coeff_idx, o_poly_idx, o_poly_last} = mem[rd_ptr];

  // Lanes are judged in ascending nibble order; lane_off packs accepted
  // lanes into consecutive FIFO slots and the cap at N_COEFF drops the rest.
  always_comb begin
    cnt_nxt = coeff_cnt;
    push_n  = '0;
    acc     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      nib[l] = blk[4*l +: 4];
      if (eta4)
        val[l] = nib[l];
      else if (nib[l] >= 4'd10)
        val[l] = nib[l] - 4'd10;
      else if (nib[l] >= 4'd5)
        val[l] = nib[l] - 4'd5;
      else
        val[l] = nib[l];
      ent[l]      = {val[l], 8'(cnt_nxt), poly_idx, (cnt_nxt == LAST_C)};
      lane_off[l] = push_n[PW-1:0];
      if (do_proc && (cnt_nxt < N_C) && (eta4 ? (nib[l] < 4'd9) : (nib[l] < 4'd15))) begin
        acc[l]  = 1'b1;
        cnt_nxt = cnt_nxt + CCW'(1);
        push_n  = push_n + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned l = 0; l < LANES; l++)
        if (acc[l]) mem[wr_ptr + lane_off[l]] <= ent[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      eta4          <= 1'b0;
      num_last      <= '0;
      row_base      <= '0;
      rho           <= '0;
      poly_idx      <= '0;
      coeff_cnt     <= '0;
      bit_ptr       <= '0;
      blk           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_shake_start <= 1'b0;
      o_shake_seed  <= '0;
      o_squeeze_req <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else if (i_abort) begin
      state         <= S_IDLE;
      poly_idx      <= '0;
      coeff_cnt     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_shake_start <= 1'b0;
      o_squeeze_req <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_shake_start <= 1'b0;
      o_squeeze_req <= 1'b0;
      o_done        <= 1'b0;
      wr_ptr        <= wr_ptr + push_n[PW-1:0];
      rd_ptr        <= rd_ptr + PW'(pop);
      count         <= count + push_n - CW'(pop);
      unique case (state)
        S_IDLE: if (i_start) begin
          eta4      <= i_eta_mode;
          num_last  <= (i_num_poly == 4'd0) ? 4'd0 : i_num_poly - 4'd1;
          row_base  <= i_row_base;
          rho       <= i_rho_prime;
          poly_idx  <= '0;
          coeff_cnt <= '0;
          o_busy    <= 1'b1;
          state     <= S_START;
        end
        S_START: begin
          o_shake_start <= 1'b1;
          o_shake_seed  <= {row_base + {12'd0, poly_idx}, rho};
          state         <= S_REQ;
        end
        S_REQ: begin
          o_squeeze_req <= 1'b1;
          state         <= S_WAIT_ACK;
        end
        S_WAIT_ACK: if (!i_squeeze_valid) state <= S_WAIT_DATA;
        S_WAIT_DATA: if (i_squeeze_valid) begin
          blk     <= i_squeeze_data;
          bit_ptr <= '0;
          state   <= S_PROCESS;
        end
        // The block shifts down each step so lanes always read the low nibbles;
        // bit_ptr only tracks when the block is used up.
        S_PROCESS: if (do_proc) begin
          blk       <= blk >> (4 * LANES);
          bit_ptr   <= bit_ptr + STEP;
          coeff_cnt <= cnt_nxt;
          if (cnt_nxt == N_C)
            state <= S_NEXT_POLY;
          else if (bit_ptr + STEP == RATE_L)
            state <= S_REQ;
        end
        S_NEXT_POLY: begin
          coeff_cnt <= '0;
          poly_idx  <= poly_idx + 4'd1;
          state     <= (poly_idx == num_last) ? S_DRAIN : S_START;
        end
        S_DRAIN: if (count == '0) begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rejsam_eta_vec.sv
// Randomized bench for rejsam_eta_vec: a SHAKE responder and consumer feed a
// behavioural rejection-sampling model whose expected stream is compared on every pop.
module tb_rejsam_eta_vec;

  localparam int RATE_BITS = 1088;
  localparam int N_COEFF   = 256;
  localparam int NNIB      = RATE_BITS / 4;
  localparam int P_RAND    = 0;
  localparam int P_THREE   = 1;
  localparam int P_FE94    = 2;
  localparam int P_FFIRST  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_start, i_abort, i_eta_mode;
  logic [3:0]           i_num_poly;
  logic [15:0]          i_row_base;
  logic [511:0]         i_rho_prime;
  logic                 o_shake_start;
  logic [527:0]         o_shake_seed;
  logic                 i_shake_busy;
  logic                 o_squeeze_req;
  logic                 i_squeeze_valid;
  logic [RATE_BITS-1:0] i_squeeze_data;
  logic                 o_coeff_valid, i_coeff_ready;
  logic [3:0]           o_coeff_data;
  logic [7:0]           o_coeff_idx;
  logic [3:0]           o_poly_idx;
  logic                 o_poly_last, o_busy, o_done;

  rejsam_eta_vec #(.N_COEFF(N_COEFF), .RATE_BITS(RATE_BITS), .LANES(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_eta_mode(i_eta_mode), .i_num_poly(i_num_poly), .i_row_base(i_row_base),
    .i_rho_prime(i_rho_prime), .o_shake_start(o_shake_start), .o_shake_seed(o_shake_seed),
    .i_shake_busy(i_shake_busy), .o_squeeze_req(o_squeeze_req),
    .i_squeeze_valid(i_squeeze_valid), .i_squeeze_data(i_squeeze_data),
    .o_coeff_valid(o_coeff_valid), .i_coeff_ready(i_coeff_ready),
    .o_coeff_data(o_coeff_data), .o_coeff_idx(o_coeff_idx), .o_poly_idx(o_poly_idx),
    .o_poly_last(o_poly_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic         cfg_eta;
  int           cfg_pat;
  int unsigned  cfg_rdy = 100;
  logic [15:0]  cfg_row;
  logic [511:0] cfg_rho;
  int           starts = 0, run_base = 0, sq_cnt = 0, sq_base = 0;
  int           done_cnt = 0, done_base = 0;
  int           m_cnt = 0, m_poly = 0, m_blk = 0;
  int           sh_delay = 0;
  bit           sh_pend = 0;
  logic [RATE_BITS-1:0] sh_blk;
  logic [16:0]  exp_q [$];

  task automatic check(input string tag, input logic [527:0] got, input logic [527:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RATE_BITS-1:0] gen_block(input int pat, input int bidx);
    logic [RATE_BITS-1:0] b;
    b = '0;
    for (int k = 0; k < NNIB; k++) begin
      logic [3:0] n;
      case (pat)
        P_THREE:  n = 4'h3;
        P_FE94:   n = (k % 4 == 0) ? 4'hF : (k % 4 == 1) ? 4'hE : (k % 4 == 2) ? 4'h9 : 4'h4;
        P_FFIRST: n = (bidx == 0) ? 4'hF : 4'h3;
        default:  n = 4'($urandom_range(0, 15));
      endcase
      b[4*k +: 4] = n;
    end
    return b;
  endfunction

  // Reference: scan a block's nibbles in order, keep the accepted values until N_COEFF.
  task automatic model_block(input logic [RATE_BITS-1:0] b);
    for (int k = 0; k < NNIB; k++) begin
      int v;
      v = int'(b[4*k +: 4]);
      if (m_cnt < N_COEFF && (cfg_eta ? v < 9 : v < 15)) begin
        exp_q.push_back({4'(cfg_eta ? v : v % 5), 8'(m_cnt), 4'(m_poly), (m_cnt == N_COEFF - 1)});
        m_cnt++;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        i_coeff_ready = ($urandom_range(0, 99) < cfg_rdy);
        if (o_coeff_valid && i_coeff_ready) begin
          if (exp_q.size() == 0)
            check("coeff_unexpected", 528'(exp_q.size()), 528'd1);
          else
            check("coeff", 528'({o_coeff_data, o_coeff_idx, o_poly_idx, o_poly_last}),
                  528'(exp_q.pop_front()));
        end
        if (o_shake_start) begin
          check("seed", o_shake_seed, {16'(cfg_row + 16'(starts - run_base)), cfg_rho});
          m_poly = starts - run_base;
          m_cnt  = 0;
          m_blk  = 0;
          starts++;
        end
        if (o_squeeze_req) begin
          check("req_needed", 528'(m_cnt < N_COEFF), 528'd1);
          sq_cnt++;
          i_squeeze_valid = 1'b0;
          sh_pend  = 1;
          sh_delay = $urandom_range(1, 3);
        end else if (sh_pend) begin
          sh_delay--;
          if (sh_delay == 0) begin
            sh_blk = gen_block(cfg_pat, m_blk);
            m_blk++;
            model_block(sh_blk);
            i_squeeze_data  = sh_blk;
            i_squeeze_valid = 1'b1;
            sh_pend = 0;
          end
        end
        if (!o_busy) begin
          sh_pend = 0;
          i_squeeze_valid = 1'b0;
        end
        if (o_done) begin
          check("done_busy", 528'(o_busy), 528'd0);
          done_cnt++;
        end
      end
    end
  end

  task automatic start_run(input logic eta, input int np, input int pat, input int unsigned rdy,
                           input logic [15:0] row);
    cfg_eta = eta; cfg_pat = pat; cfg_rdy = rdy; cfg_row = row;
    for (int i = 0; i < 16; i++) cfg_rho[32*i +: 32] = $urandom;
    run_base = starts; sq_base = sq_cnt; done_base = done_cnt;
    i_eta_mode = eta; i_num_poly = 4'(np); i_row_base = row; i_rho_prime = cfg_rho;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_eta_mode = ~eta; i_num_poly = 4'($urandom); i_row_base = 16'($urandom);
    i_rho_prime = ~cfg_rho;
  endtask

  task automatic finish_run(input int np, input int exp_sq, input bit dbl);
    if (dbl) begin
      repeat (4) @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end
    for (int c = 0; c < 40000 && done_cnt == done_base; c++) @(negedge clk);
    check("done_seen", 528'(done_cnt - done_base), 528'd1);
    repeat (3) @(negedge clk);
    check("done_single", 528'(done_cnt - done_base), 528'd1);
    check("busy_idle", 528'(o_busy), 528'd0);
    check("queue_empty", 528'(exp_q.size()), 528'd0);
    check("poly_starts", 528'(starts - run_base), 528'((np == 0) ? 1 : np));
    if (exp_sq > 0) check("squeezes", 528'(sq_cnt - sq_base), 528'(exp_sq));
    if (done_cnt == done_base) begin
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic eta, input int np, input int pat, input int unsigned rdy,
                     input bit dbl, input int exp_sq, input logic [15:0] row);
    start_run(eta, np, pat, rdy, row);
    finish_run(np, exp_sq, dbl);
  endtask

  initial begin
    int d0, st0;
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_eta_mode = 1'b0; i_num_poly = '0;
    i_row_base = '0; i_rho_prime = '0; i_shake_busy = 1'b0; i_squeeze_valid = 1'b0;
    i_squeeze_data = '0; i_coeff_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 528'({o_busy, o_done, o_coeff_valid, o_squeeze_req, o_shake_start,
                                 o_coeff_data, o_coeff_idx, o_poly_idx, o_poly_last}), '0);
    check("reset_seed", o_shake_seed, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b1, 1, P_THREE,  100, 0, 1, 16'h1234);
    run(1'b0, 1, P_FE94,   100, 0, 2, 16'h0042);
    run(1'b0, 1, P_FFIRST, 100, 0, 2, 16'h7000);
    run(1'b1, 3, P_RAND,   30,  1, -1, 16'hFFFF);
    for (int r = 0; r < 4; r++)
      run(1'($urandom_range(0, 1)), $urandom_range(0, 3), P_RAND,
          $urandom_range(20, 100), 0, -1, 16'($urandom));

    start_run(1'b0, 2, P_RAND, 50, 16'h0100);
    for (int c = 0; c < 20000 && (starts - run_base) < 2; c++) @(negedge clk);
    check("abort_reach_poly1", 528'(starts - run_base), 528'd2);
    repeat (25) @(negedge clk);
    d0 = done_cnt;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_busy", 528'(o_busy), 528'd0);
    check("abort_valid", 528'(o_coeff_valid), 528'd0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 528'(done_cnt - d0), 528'd0);
    exp_q.delete();
    run(1'b1, 2, P_RAND, 60, 0, -1, 16'($urandom));

    st0 = starts;
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    check("abort_beats_start", 528'(o_busy), 528'd0);
    repeat (5) @(negedge clk);
    check("abort_no_shake", 528'(starts - st0), 528'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
